aes_mode_ctrl: RTL
==================

Name: aes_mode_ctrl

Overview:
- Parametrised block-chaining controller between a valid/ready streaming interface and the iterative AES block core (Din/Key/Drdy/Krdy/EncDec/BSY/Dvld contract).
- Adds ECB, CBC and CTR modes, multi-block messages, IV/counter handling and a one-entry output buffer.
- Lets the core process whole messages without host-side chaining logic.

Parameters:
BLK_W, 128, block and IV width (core data width)
KEY_W, 128, key width passed through to core
CTR_W, 32, low IV bits incremented per block in CTR mode (1..BLK_W)
CNT_W, 16, width of block counter BlkCnt

Ports:
CLK  in  1  clock, rising edge
RSTn  in  1  asynchronous active-low reset; same net drives the core
Mode  in  2  00 ECB, 01 CBC, 10 CTR, 11 reserved; sampled on Start
Dec  in  1  1 = decrypt; sampled on Start
Key  in  KEY_W  key; encryption key for CTR (either direction), direction key otherwise
KeyLd  in  1  one-cycle key-load request
Iv  in  BLK_W  IV (CBC) or initial counter (CTR); sampled on Start
Start  in  1  one-cycle message start; latches Mode/Dec/Iv and clears BlkCnt
SData  in  BLK_W  input block
SValid  in  1  input block valid
SReady  out  1  input accepted when SValid&SReady
SLast  in  1  marks final block of message
MData  out  BLK_W  output block
MValid  out  1  output valid; held until MReady
MReady  in  1  downstream ready
MLast  out  1  final-block marker aligned with MData
CDin  out  BLK_W  core Din
CKey  out  KEY_W  core Key
CDrdy  out  1  core Drdy pulse
CKrdy  out  1  core Krdy pulse
CEncDec  out  1  core EncDec
CBSY  in  1  core BSY
CDvld  in  1  core Dvld pulse
CDout  in  BLK_W  core Dout; valid when CDvld=1
Busy  out  1  high in any state other than IDLE/READY
BlkCnt  out  CNT_W  blocks completed since Start; wraps modulo 2^CNT_W
Err  out  1  sticky error; cleared by Start

Behaviour:
- Reset values: SReady, MValid, MLast, CDrdy, CKrdy, CEncDec, Busy, Err = 0; MData, CDin, CKey, BlkCnt, chaining register = 0; state IDLE.
- Core contract: core captures CDin on CDrdy=1 when CBSY=0. CDvld is a one-cycle pulse with CDout valid. CKrdy starts the key schedule; CBSY is high while it runs.
- States:
  - IDLE: no key loaded. KeyLd -> KEY.
  - KEY: CKrdy=1 for exactly one cycle with CKey=Key, then wait CBSY=0 -> READY.
  - READY: SReady=1 when output buffer is empty, or draining this cycle. On accept, form CDin -> ISSUE.
  - ISSUE: CDrdy=1 for one cycle -> WAIT.
  - WAIT: on CDvld form MData, set MValid and MLast, BlkCnt+1 -> READY.
- Input/output formation, with R = chaining register:
  - ECB: CDin=SData; MData=CDout.
  - CBC enc: CDin=SData^R; MData=CDout; R<=CDout.
  - CBC dec: CDin=SData; latch SData into C_hold; MData=CDout^R; R<=C_hold.
  - CTR: CDin=R; latch SData; MData=CDout^SData_hold; R[CTR_W-1:0]<=R[CTR_W-1:0]+1 modulo 2^CTR_W; upper bits unchanged.
- CEncDec: equals latched Dec for ECB/CBC; forced 0 in CTR.
- Start: loads R<=Iv, latches Mode/Dec, clears BlkCnt and Err. Ignored (Err<=1) unless in READY with MValid=0.
- KeyLd: accepted in IDLE or READY with MValid=0; otherwise ignored and Err<=1.
- Mode=11 on Start: Err<=1; block then behaves as ECB.
- SLast: propagates to MLast. After the last block, R is left as updated and a new Start is required for the next message.
- Start and SValid in the same cycle: Start wins; SReady=0 that cycle.
- Latency: accept-to-CDrdy is 1 cycle; CDvld-to-MValid is 1 cycle (registered).
- MData and MLast stay stable while MValid=1 and MReady=0.
- RSTn low mid-operation: immediate return to reset values; the key must be reloaded.

Decomposition:
- Shared package aes_pkg: mode encodings (MODE_ECB/CBC/CTR), state enumeration, and the FIPS-197 and SP800-38A test constants.
- One natural sub-module, aes_ctr_inc: parametrised CTR_W low-field incrementer with wrap.

Test Plan:
- ECB enc: Key=000102030405060708090a0b0c0d0e0f, SData=00112233445566778899aabbccddeeff -> MData=69c4e0d86a7b0430d8cdb78070b4c55a, BlkCnt=1.
- ECB dec: Key=13111d7fe3944a17f307a78b4d2b30c5, Dec=1, SData=69c4e0d8... -> MData=00112233...ff.
- CBC enc (SP800-38A): Key=2b7e151628aed2a6abf7158809cf4f3c, Iv=000102...0f. Block 6bc1bee22e409f96e93d7e117393172a -> 7649abac8119b246cee98e9b12e9197d. Block 2 then chains correctly (5086cb9b507219ee95db113a917678b2).
- CTR enc: Iv=f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, block 1 6bc1bee2... -> 874d6191b620e3261bef6864990db6ce. Second CDin ends ...fcfdff00.
- CTR wrap: Iv low 32 bits=ffffffff -> second CDin low bits=00000000, upper 96 bits unchanged. Also: MReady held 0 for 5 cycles -> SReady=0 and MData stable throughout.
- Error/reset: Mode=11 on Start -> Err=1. RSTn pulsed during WAIT -> all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared encodings and reference vectors for the AES block-chaining controller.
// The reference vectors are FIPS-197 Appendix C.1 and SP800-38A F.2.1/F.5.1.
package aes_pkg;

  typedef enum logic [1:0] {
    MODE_ECB = 2'b00,
    MODE_CBC = 2'b01,
    MODE_CTR = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KEY   = 3'd1,
    ST_KWAIT = 3'd2,
    ST_READY = 3'd3,
    ST_ISSUE = 3'd4,
    ST_WAIT  = 3'd5
  } state_e;

  localparam logic [127:0] FIPS197_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS197_DKEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] FIPS197_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS197_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  localparam logic [127:0] SP_KEY       = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] SP_PT1       = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] SP_PT2       = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] SP_CBC_IV    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SP_CBC_CT1   = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] SP_CBC_CT2   = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] SP_CTR_IV    = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] SP_CTR_KS1   = 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
  localparam logic [127:0] SP_CTR_KS2   = 128'h362b7c3c6773516318a077d7fc5073ae;
  localparam logic [127:0] SP_CTR_CT1   = 128'h874d6191b620e3261bef6864990db6ce;
  localparam logic [127:0] SP_CTR_CT2   = 128'h9806f66b7970fdff8617187bb9fffdff;

endpackage

// File: rtl/aes_ctr_inc.sv
// Increments the low CTR_W bits of a counter block modulo 2^CTR_W;
// the upper bits pass through untouched.
module aes_ctr_inc #(
  parameter int unsigned BLK_W = 128,
  parameter int unsigned CTR_W = 32
) (
  input  logic [BLK_W-1:0] blk_i,
  output logic [BLK_W-1:0] blk_o
);

  if (CTR_W >= BLK_W) begin : g_full
    assign blk_o = blk_i + BLK_W'(1);
  end else begin : g_field
    assign blk_o = {blk_i[BLK_W-1:CTR_W], blk_i[CTR_W-1:0] + CTR_W'(1)};
  end

endmodule

// File: rtl/aes_mode_ctrl.sv
// Block-chaining controller: drives an iterative AES core through ECB/CBC/CTR
// messages with IV/counter chaining and a one-entry output buffer.
module aes_mode_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned BLK_W = 128,
  parameter int unsigned KEY_W = 128,
  parameter int unsigned CTR_W = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [1:0]       Mode,
  input  logic             Dec,
  input  logic [KEY_W-1:0] Key,
  input  logic             KeyLd,
  input  logic [BLK_W-1:0] Iv,
  input  logic             Start,
  input  logic [BLK_W-1:0] SData,
  input  logic             SValid,
  output logic             SReady,
  input  logic             SLast,
  output logic [BLK_W-1:0] MData,
  output logic             MValid,
  input  logic             MReady,
  output logic             MLast,
  output logic [BLK_W-1:0] CDin,
  output logic [KEY_W-1:0] CKey,
  output logic             CDrdy,
  output logic             CKrdy,
  output logic             CEncDec,
  input  logic             CBSY,
  input  logic             CDvld,
  input  logic [BLK_W-1:0] CDout,
  output logic             Busy,
  output logic [CNT_W-1:0] BlkCnt,
  output logic             Err
);

  state_e           state_q, state_d;
  mode_e            mode_q;
  logic             dec_q;
  logic [BLK_W-1:0] chain_q, hold_q, cdin_q, mdata_q;
  logic [KEY_W-1:0] ckey_q;
  logic             mvalid_q, mlast_q, last_q, err_q, done_q;
  logic [CNT_W-1:0] cnt_q;
  logic [BLK_W-1:0] chain_inc;

  logic key_ok, start_ok, accept, core_done;

  aes_ctr_inc #(.BLK_W(BLK_W), .CTR_W(CTR_W)) u_ctr_inc (
    .blk_i(chain_q),
    .blk_o(chain_inc)
  );

  assign key_ok    = KeyLd && ((state_q == ST_IDLE) || (state_q == ST_READY && !mvalid_q));
  assign start_ok  = Start && (state_q == ST_READY) && !mvalid_q;
  assign accept    = SReady && SValid;
  assign core_done = (state_q == ST_WAIT) && CDvld;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Start and KeyLd take the cycle, so no block can be accepted alongside them;
  // done_q holds off input after a last block until the next Start.
  always_comb begin
    state_d = state_q;
    SReady  = 1'b0;
    CDrdy   = 1'b0;
    CKrdy   = 1'b0;
    Busy    = !(state_q == ST_IDLE || state_q == ST_READY);
    if (state_q == ST_READY)
      SReady = (!mvalid_q || MReady) && !Start && !KeyLd && !done_q;
    unique case (state_q)
      ST_IDLE:  if (key_ok) state_d = ST_KEY;
      ST_KEY: begin
        CKrdy   = 1'b1;
        state_d = ST_KWAIT;
      end
      ST_KWAIT: if (!CBSY) state_d = ST_READY;
      ST_READY: begin
        if (key_ok)      state_d = ST_KEY;
        else if (accept) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        CDrdy = 1'b1;
        if (!CBSY) state_d = ST_WAIT;
      end
      ST_WAIT:  if (CDvld) state_d = ST_READY;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      mode_q   <= MODE_ECB;
      dec_q    <= 1'b0;
      chain_q  <= '0;
      hold_q   <= '0;
      cdin_q   <= '0;
      mdata_q  <= '0;
      ckey_q   <= '0;
      mvalid_q <= 1'b0;
      mlast_q  <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (key_ok) ckey_q <= Key;

      if (start_ok) begin
        chain_q <= Iv;
        mode_q  <= (Mode == MODE_RSV) ? MODE_ECB : mode_e'(Mode);
        dec_q   <= Dec;
        cnt_q   <= '0;
        done_q  <= 1'b0;
        err_q   <= (Mode == MODE_RSV);
      end
      if ((Start && !start_ok) || (KeyLd && !key_ok)) err_q <= 1'b1;

      if (accept) begin
        last_q <= SLast;
        hold_q <= SData;
        case (mode_q)
          MODE_CBC: cdin_q <= dec_q ? SData : (SData ^ chain_q);
          MODE_CTR: cdin_q <= chain_q;
          default:  cdin_q <= SData;
        endcase
      end

      if (core_done) begin
        mvalid_q <= 1'b1;
        mlast_q  <= last_q;
        cnt_q    <= cnt_q + CNT_W'(1);
        if (last_q) done_q <= 1'b1;
        case (mode_q)
          MODE_CBC: begin
            if (dec_q) begin
              mdata_q <= CDout ^ chain_q;
              chain_q <= hold_q;
            end else begin
              mdata_q <= CDout;
              chain_q <= CDout;
            end
          end
          MODE_CTR: begin
            mdata_q <= CDout ^ hold_q;
            chain_q <= chain_inc;
          end
          default:  mdata_q <= CDout;
        endcase
      end else if (mvalid_q && MReady) begin
        mvalid_q <= 1'b0;
      end
    end
  end

  assign MData   = mdata_q;
  assign MValid  = mvalid_q;
  assign MLast   = mlast_q;
  assign CDin    = cdin_q;
  assign CKey    = ckey_q;
  assign CEncDec = (mode_q == MODE_CTR) ? 1'b0 : dec_q;
  assign BlkCnt  = cnt_q;
  assign Err     = err_q;

endmodule
